systolic_skew_feeder: RTL and testbench

Input staging stage directly upstream of the systolic array. Accepts one unskewed reduction step per beat (one A column slice across all rows, one B row slice across all columns), applies the diagonal skew the array needs (row i of A and column j of B delayed by i and j cycles respectively), and zero-pads before, between and after valid beats. It counts reduction steps, flushes the array pipeline, and pulses the array's done flag so accumulated results in out_c are final.

---
 rtl/systolic_skew_feeder_pkg.sv | 17 +
 rtl/systolic_skew_feeder_skew_delay_line.sv | 29 ++
 rtl/systolic_skew_feeder.sv | 121 ++++++++++++
 tb/tb_systolic_skew_feeder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and constants for the systolic array input feeder.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DONE
  } state_t;

  // Zero cycles needed after the last beat so its products reach the far
  // corner PE and settle through the accumulate pipeline.
  function automatic int flush_len(input int arr_height, input int arr_width, input int drain_extra);
    return arr_height + arr_width - 1 + drain_extra;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// Fixed-depth register chain used to skew one lane of operands in time.
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_reg[s] <= '0;
      end
    end else begin
      stage_reg[0] <= d;
      for (int s = 1; s < DEPTH; s++) begin
        stage_reg[s] <= stage_reg[s-1];
      end
    end
  end

  assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Input staging for the systolic array: diagonal operand skew, zero padding,
// reduction-step counting, pipeline flush and the array done pulse.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ARR_HEIGHT  = 4,
  parameter int ARR_WIDTH   = 4,
  parameter int K_BITS      = 16,
  parameter int DRAIN_EXTRA = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [K_BITS-1:0]           k_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ARR_HEIGHT*WIDTH-1:0] in_a,
  input  logic [ARR_WIDTH*WIDTH-1:0]  in_b,
  output logic [ARR_HEIGHT*WIDTH-1:0] out_a,
  output logic [ARR_WIDTH*WIDTH-1:0]  out_b,
  output logic                        out_done_flag,
  output logic                        busy
);

  localparam int                FLUSH_LEN  = flush_len(ARR_HEIGHT, ARR_WIDTH, DRAIN_EXTRA);
  localparam logic [K_BITS-1:0] FLUSH_LAST = K_BITS'(FLUSH_LEN - 1);

  state_t            state_reg, state_next;
  logic [K_BITS-1:0] kcnt_reg, kcnt_next;
  logic [K_BITS-1:0] fcnt_reg, fcnt_next;
  logic [K_BITS-1:0] klen_reg, klen_next;
  logic              accept;

  // Only FEED takes beats; every other cycle (and every bubble) pushes zeros.
  assign accept = in_valid && (state_reg == FEED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      kcnt_reg  <= '0;
      fcnt_reg  <= '0;
      klen_reg  <= '0;
    end else begin
      state_reg <= state_next;
      kcnt_reg  <= kcnt_next;
      fcnt_reg  <= fcnt_next;
      klen_reg  <= klen_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    kcnt_next     = kcnt_reg;
    fcnt_next     = fcnt_reg;
    klen_next     = klen_reg;
    in_ready      = 1'b0;
    busy          = 1'b1;
    out_done_flag = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start && (k_len != '0)) begin
          state_next = FEED;
          kcnt_next  = '0;
          klen_next  = k_len;
        end
      end
      FEED: begin
        in_ready = 1'b1;
        if (in_valid) begin
          kcnt_next = kcnt_reg + K_BITS'(1);
          if (kcnt_reg == klen_reg - K_BITS'(1)) begin
            state_next = FLUSH;
            fcnt_next  = '0;
          end
        end
      end
      FLUSH: begin
        if (fcnt_reg == FLUSH_LAST) begin
          state_next = DONE;
        end else begin
          fcnt_next = fcnt_reg + K_BITS'(1);
        end
      end
      DONE: begin
        out_done_flag = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane i of A and lane j of B get i+1 / j+1 register stages.
  genvar gi;
  generate
    for (gi = 0; gi < ARR_HEIGHT; gi++) begin : g_a_lane
      skew_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (gi + 1)
      ) u_skew_a (
        .clk   (clk),
        .reset (reset),
        .d     (accept ? in_a[gi*WIDTH +: WIDTH] : {WIDTH{1'b0}}),
        .q     (out_a[gi*WIDTH +: WIDTH])
      );
    end
    for (gi = 0; gi < ARR_WIDTH; gi++) begin : g_b_lane
      skew_delay_line #(
        .WIDTH (WIDTH),
        .DEPTH (gi + 1)
      ) u_skew_b (
        .clk   (clk),
        .reset (reset),
        .d     (accept ? in_b[gi*WIDTH +: WIDTH] : {WIDTH{1'b0}}),
        .q     (out_b[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench: skew timing against a pushed-value history, job timing
// from the flush-length rule, and results through a behavioural integer array.
module tb_systolic_skew_feeder;

  localparam int W  = 16;
  localparam int H  = 4;
  localparam int AW = 4;
  localparam int KB = 16;
  localparam int DE = 2;
  localparam int FL = H + AW - 1 + DE;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [KB-1:0]   k_len = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [H*W-1:0]  in_a = '0;
  logic [AW*W-1:0] in_b = '0;
  logic [H*W-1:0]  out_a;
  logic [AW*W-1:0] out_b;
  logic            out_done_flag;
  logic            busy;

  int total = 0;
  int bad   = 0;

  logic exp_accept = 1'b0;
  logic clr = 1'b0;
  logic mon_en = 1'b0;
  int   cyc = 0;
  int   skew_bad = 0;
  logic [H*W-1:0]  hist_a [16];
  logic [AW*W-1:0] hist_b [16];
  logic [W-1:0]    ar  [H][AW];
  logic [W-1:0]    br  [H][AW];
  logic [31:0]     acc [H][AW];

  systolic_skew_feeder #(
    .WIDTH       (W),
    .ARR_HEIGHT  (H),
    .ARR_WIDTH   (AW),
    .K_BITS      (KB),
    .DRAIN_EXTRA (DE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .k_len         (k_len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_done_flag (out_done_flag),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // History of what should have entered the skew lines at each edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < 8; d++) begin
        hist_a[(cyc + 17 - d) % 16] <= '0;
        hist_b[(cyc + 17 - d) % 16] <= '0;
      end
    end else begin
      hist_a[(cyc + 1) % 16] <= exp_accept ? in_a : '0;
      hist_b[(cyc + 1) % 16] <= exp_accept ? in_b : '0;
    end
    cyc <= cyc + 1;
  end

  function automatic logic [H*W-1:0] exp_a();
    logic [H*W-1:0] r;
    for (int i = 0; i < H; i++) r[i*W +: W] = hist_a[(cyc + 16 - i) % 16][i*W +: W];
    return r;
  endfunction

  function automatic logic [AW*W-1:0] exp_b();
    logic [AW*W-1:0] r;
    for (int j = 0; j < AW; j++) r[j*W +: W] = hist_b[(cyc + 16 - j) % 16][j*W +: W];
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en && (out_a !== exp_a() || out_b !== exp_b())) begin
      skew_bad <= skew_bad + 1;
      if (skew_bad < 8)
        $display("  skew detail cyc=%0d out_a=%h expected=%h out_b=%h expected=%h",
                 cyc, out_a, exp_a(), out_b, exp_b());
    end
  end

  // Behavioural integer output-stationary array fed by the DUT outputs.
  function automatic logic [W-1:0] a_into(int i, int j);
    if (j == 0) return out_a[i*W +: W];
    return ar[i][j-1];
  endfunction

  function automatic logic [W-1:0] b_into(int i, int j);
    if (i == 0) return out_b[j*W +: W];
    return br[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < H; i++) begin
      for (int j = 0; j < AW; j++) begin
        ar[i][j]  <= a_into(i, j);
        br[i][j]  <= b_into(i, j);
        acc[i][j] <= clr ? 32'd0 : acc[i][j] + 32'(a_into(i, j)) * 32'(b_into(i, j));
      end
    end
  end

  // mode 0 random data, 1 fixed {1,2,3,4}/{5,6,7,8}, 2 A=identity.
  // bub 0 none, 1 random bubbles, 2 one bubble after the first beat.
  task automatic run_job(input int k, input int mode, input int bub, input bit poke_start, input string tag);
    logic [W-1:0] ba [16][H];
    logic [W-1:0] bb [16][AW];
    logic [31:0]  ec;
    int cnt, nerr, sb0, bubbled;
    bit v;
    sb0 = skew_bad;
    bubbled = 0;
    start = 1'b1; k_len = KB'(k); clr = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; clr = 1'b0; k_len = KB'($urandom);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL %s start_accept: in_ready=%b busy=%b required 1 1", tag, in_ready, busy);
    end
    cnt = 0;
    nerr = 0;
    while (cnt < k) begin
      if (in_ready !== 1'b1 || out_done_flag !== 1'b0 || busy !== 1'b1) nerr++;
      v = 1'b1;
      if (bub == 1) v = ($urandom_range(0, 2) != 0);
      if (bub == 2 && cnt == 1 && bubbled == 0) begin v = 1'b0; bubbled = 1; end
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      if (v) begin
        for (int i = 0; i < H; i++) begin
          if (mode == 1) in_a[i*W +: W] = W'(i + 1);
          if (mode == 2) in_a[i*W +: W] = (i == cnt) ? W'(1) : W'(0);
          ba[cnt][i] = in_a[i*W +: W];
        end
        for (int j = 0; j < AW; j++) begin
          if (mode == 1) in_b[j*W +: W] = W'(j + 5);
          if (mode == 2) in_b[j*W +: W] = W'($urandom_range(0, 255));
          bb[cnt][j] = in_b[j*W +: W];
        end
      end
      in_valid = v; exp_accept = v;
      if (poke_start && cnt == 1) begin start = 1'b1; k_len = KB'(1); end
      @(posedge clk);
      if (v) cnt++;
      @(negedge clk);
      in_valid = 1'b0; exp_accept = 1'b0; start = 1'b0;
    end
    total++;
    if (nerr != 0) begin
      bad++; $display("FAIL %s feed_phase: %0d cycles with wrong in_ready/busy/done, required 0", tag, nerr);
    end
    nerr = 0;
    for (int f = 0; f < FL; f++) begin
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_done_flag !== 1'b0) nerr++;
      in_valid = 1'($urandom_range(0, 1));
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      if (f == 2) begin start = 1'b1; k_len = 16'd3; end
      @(posedge clk); @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    total++;
    if (nerr != 0) begin
      bad++; $display("FAIL %s flush_phase: %0d cycles with wrong in_ready/busy/done, required 0", tag, nerr);
    end
    total++;
    if (out_done_flag !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL %s done_pulse: done=%b busy=%b required 1 1", tag, out_done_flag, busy);
    end
    nerr = 0;
    for (int i = 0; i < H; i++) begin
      for (int j = 0; j < AW; j++) begin
        ec = 32'd0;
        for (int kk = 0; kk < k; kk++) ec = ec + 32'(ba[kk][i]) * 32'(bb[kk][j]);
        if (acc[i][j] !== ec) begin
          nerr++;
          if (nerr <= 2) $display("  result detail c[%0d][%0d]=%h expected=%h", i, j, acc[i][j], ec);
        end
      end
    end
    total++;
    if (nerr != 0) begin
      bad++; $display("FAIL %s result_c: %0d wrong elements, required 0", tag, nerr);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (out_done_flag !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL %s back_idle: done=%b busy=%b in_ready=%b required 0 0 0",
                      tag, out_done_flag, busy, in_ready);
    end
    total++;
    if (skew_bad !== sb0) begin
      bad++; $display("FAIL %s skew_lanes: %0d skewed cycles wrong, required 0", tag, skew_bad - sb0);
    end
    $display("job %s k=%0d done", tag, k);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++;
    if (out_a !== '0 || out_b !== '0 || out_done_flag !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_state: out_a=%h out_b=%h done=%b in_ready=%b busy=%b required all 0",
                      out_a, out_b, out_done_flag, in_ready, busy);
    end
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_zero_klen();
    int nerr, sb0;
    sb0 = skew_bad;
    nerr = 0;
    start = 1'b1; k_len = '0; in_valid = 1'b1; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_done_flag !== 1'b0) nerr++;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (nerr != 0 || skew_bad !== sb0) begin
      bad++; $display("FAIL zero_klen: %0d bad cycles, %0d skew errors, required 0 0", nerr, skew_bad - sb0);
    end
    $display("job zero_klen ignored");
  endtask

  task automatic test_reset_mid();
    int nerr;
    start = 1'b1; k_len = 16'd5;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; exp_accept = 1'b1; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; exp_accept = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    total++;
    if (out_a !== '0 || out_b !== '0 || in_ready !== 1'b0 || busy !== 1'b0 || out_done_flag !== 1'b0) begin
      bad++; $display("FAIL reset_mid: out_a=%h out_b=%h in_ready=%b busy=%b done=%b required all 0",
                      out_a, out_b, in_ready, busy, out_done_flag);
    end
    nerr = 0;
    for (int c = 0; c < 16; c++) begin
      if (out_done_flag !== 1'b0 || busy !== 1'b0) nerr++;
      @(posedge clk); @(negedge clk);
    end
    total++;
    if (nerr != 0) begin
      bad++; $display("FAIL reset_mid_nodone: %0d cycles with done/busy after abort, required 0", nerr);
    end
    $display("job reset_mid aborted");
  endtask

  task automatic test_single_beat();
    run_job(1, 1, 0, 1'b0, "single_beat");
  endtask

  task automatic test_bubble();
    run_job(3, 0, 2, 1'b0, "bubble");
  endtask

  task automatic test_identity();
    run_job(4, 2, 0, 1'b0, "identity");
  endtask

  task automatic test_start_during_feed();
    run_job(6, 0, 0, 1'b1, "start_in_feed");
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) run_job($urandom_range(1, 16), 0, 1, 1'b0, "random");
  endtask

  task automatic test_back_to_back();
    run_job(5, 0, 0, 1'b0, "b2b_first");
    run_job(3, 0, 1, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_zero_klen();
    test_single_beat();
    test_bubble();
    test_identity();
    test_start_during_feed();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
